// File: rtl/ps2_key_rx.sv
// PS/2 keyboard receiver: synchronises and de-glitches the PS/2 clock, deframes 11-bit frames, folds E0/F0 prefixes into flags, queues keys in a 4-entry FIFO.
// Latency: key_valid rises 2 clk cycles after the filtered falling edge of the stop bit when the FIFO was empty.
// Backpressure: key_valid/key_ready handshake; a key decoded while the FIFO is full and not popping that cycle is dropped with an overflow pulse.
//
// Ports:
//   clk, rst_n           system clock (rising edge), asynchronous active-low reset
//   ps2_clk, ps2_data    raw PS/2 lines, asynchronous to clk
//   key_code/ext/rel     FIFO head: scancode plus "preceded by E0" / "preceded by F0"
//   key_valid, key_ready head handshake; head is popped when both are high
//   frame_err            one-cycle pulse on parity, stop-bit or timeout error
//   overflow             one-cycle pulse when a decoded key is dropped (FIFO full)
module ps2_key_rx #(
    parameter int FILTER_LEN  = 8,
    parameter int TIMEOUT_CYC = 50000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [7:0] key_code,
    output logic       key_ext,
    output logic       key_rel,
    output logic       key_valid,
    input  logic       key_ready,
    output logic       frame_err,
    output logic       overflow
);

    localparam int FCW = $clog2(FILTER_LEN + 1);
    localparam int TCW = $clog2(TIMEOUT_CYC + 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2,
        STOP   = 2'd3
    } state_t;

    // ------------------------------------------------------------------
    // Two-flop synchronisers; reset to the idle line level.
    // ------------------------------------------------------------------
    logic clk_s1_q, clk_s2_q;
    logic dat_s1_q, dat_s2_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            clk_s1_q <= 1'b1;
            clk_s2_q <= 1'b1;
            dat_s1_q <= 1'b1;
            dat_s2_q <= 1'b1;
        end else begin
            clk_s1_q <= ps2_clk;
            clk_s2_q <= clk_s1_q;
            dat_s1_q <= ps2_data;
            dat_s2_q <= dat_s1_q;
        end
    end

    // ------------------------------------------------------------------
    // Clock filter: the filtered level follows the synchronised clock only
    // after FILTER_LEN consecutive samples disagree with it. Any agreeing
    // sample restarts the run, so short glitches never reach the deframer.
    // ------------------------------------------------------------------
    logic           filt_q, filt_d;
    logic           filt_prev_q;
    logic [FCW-1:0] filt_cnt_q, filt_cnt_d;
    logic           fall;

    always_comb begin
        filt_d     = filt_q;
        filt_cnt_d = '0;
        if (clk_s2_q != filt_q) begin
            if (filt_cnt_q == FCW'(FILTER_LEN - 1)) begin
                filt_d = clk_s2_q;
            end else begin
                filt_cnt_d = filt_cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            filt_q      <= 1'b1;
            filt_prev_q <= 1'b1;
            filt_cnt_q  <= '0;
        end else begin
            filt_q      <= filt_d;
            filt_prev_q <= filt_q;
            filt_cnt_q  <= filt_cnt_d;
        end
    end

    // Exactly one cycle high per filtered 1->0 transition.
    assign fall = filt_prev_q & ~filt_q;

    // ------------------------------------------------------------------
    // Deframer FSM
    // ------------------------------------------------------------------
    state_t         state_q, state_d;
    logic [2:0]     bit_cnt_q, bit_cnt_d;
    logic [7:0]     shift_q, shift_d;
    logic           par_q, par_d;
    logic [TCW-1:0] to_cnt_q, to_cnt_d;
    logic           byte_vld_q, byte_vld_d;
    logic           err_q, err_d;

    always_comb begin
        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        shift_d    = shift_q;
        par_d      = par_q;
        byte_vld_d = 1'b0;
        err_d      = 1'b0;
        to_cnt_d   = (state_q == IDLE || fall) ? '0 : to_cnt_q + 1'b1;

        unique case (state_q)
            IDLE: begin
                // A fall with data high is line noise, not a start bit.
                if (fall && !dat_s2_q) begin
                    state_d   = DATA;
                    bit_cnt_d = 3'd0;
                end
            end
            DATA: begin
                if (fall) begin
                    shift_d   = {dat_s2_q, shift_q[7:1]};
                    bit_cnt_d = bit_cnt_q + 1'b1;
                    if (bit_cnt_q == 3'd7) begin
                        state_d = PARITY;
                    end
                end
            end
            PARITY: begin
                if (fall) begin
                    par_d   = dat_s2_q;
                    state_d = STOP;
                end
            end
            STOP: begin
                if (fall) begin
                    state_d = IDLE;
                    // Odd parity over data plus parity bit, and a high stop bit.
                    if (dat_s2_q && ((^shift_q) ^ par_q)) begin
                        byte_vld_d = 1'b1;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // A stalled partial frame is abandoned; prefix flags are left alone.
        if (state_q != IDLE && !fall && to_cnt_q == TCW'(TIMEOUT_CYC - 1)) begin
            state_d  = IDLE;
            err_d    = 1'b1;
            to_cnt_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            bit_cnt_q  <= '0;
            shift_q    <= '0;
            par_q      <= 1'b0;
            to_cnt_q   <= '0;
            byte_vld_q <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            bit_cnt_q  <= bit_cnt_d;
            shift_q    <= shift_d;
            par_q      <= par_d;
            to_cnt_q   <= to_cnt_d;
            byte_vld_q <= byte_vld_d;
            err_q      <= err_d;
        end
    end

    assign frame_err = err_q;

    // ------------------------------------------------------------------
    // Prefix handling. shift_q still holds the accepted byte in the cycle
    // after the stop fall, since a new frame cannot start that quickly.
    // ------------------------------------------------------------------
    logic ext_pend_q, ext_pend_d;
    logic rel_pend_q, rel_pend_d;
    logic push;

    always_comb begin
        ext_pend_d = ext_pend_q;
        rel_pend_d = rel_pend_q;
        push       = 1'b0;
        if (byte_vld_q) begin
            if (shift_q == 8'hE0) begin
                ext_pend_d = 1'b1;
            end else if (shift_q == 8'hF0) begin
                rel_pend_d = 1'b1;
            end else begin
                // Flags are consumed even if the FIFO then drops the key.
                push       = 1'b1;
                ext_pend_d = 1'b0;
                rel_pend_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ext_pend_q <= 1'b0;
            rel_pend_q <= 1'b0;
        end else begin
            ext_pend_q <= ext_pend_d;
            rel_pend_q <= rel_pend_d;
        end
    end

    // ------------------------------------------------------------------
    // 4-entry key FIFO, entry = {code, ext, rel}
    // ------------------------------------------------------------------
    logic [9:0] mem_q [4];
    logic [1:0] wr_ptr_q, wr_ptr_d;
    logic [1:0] rd_ptr_q, rd_ptr_d;
    logic [2:0] cnt_q, cnt_d;
    logic       key_valid_q, key_valid_d;
    logic       pop, full, wr_en;

    assign pop  = key_valid_q & key_ready;
    assign full = (cnt_q == 3'd4);
    // When full, a same-cycle pop frees the head slot, which is exactly the
    // slot the write pointer addresses, so the push can still land.
    assign wr_en    = push & (~full | pop);
    assign overflow = push & full & ~pop;

    always_comb begin
        wr_ptr_d    = wr_ptr_q + {1'b0, wr_en};
        rd_ptr_d    = rd_ptr_q + {1'b0, pop};
        cnt_d       = cnt_q + {2'b00, wr_en} - {2'b00, pop};
        key_valid_d = (cnt_d != 3'd0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            cnt_q       <= '0;
            key_valid_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            cnt_q       <= cnt_d;
            key_valid_q <= key_valid_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 4; i++) begin
                mem_q[i] <= '0;
            end
        end else if (wr_en) begin
            mem_q[wr_ptr_q] <= {shift_q, ext_pend_q, rel_pend_q};
        end
    end

    // Head is only rewritten on the same edge that pops it, so it is stable
    // for as long as the consumer stalls.
    assign {key_code, key_ext, key_rel} = mem_q[rd_ptr_q];
    assign key_valid = key_valid_q;

endmodule

// File: tb/tb_ps2_key_rx.sv
module tb_ps2_key_rx;

    localparam int HALF = 16;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       ps2_clk = 1'b1;
    logic       ps2_data = 1'b1;
    logic       key_ready = 1'b0;
    logic [7:0] key_code;
    logic       key_ext, key_rel, key_valid, frame_err, overflow;

    ps2_key_rx #(.FILTER_LEN(8), .TIMEOUT_CYC(50000)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .ps2_clk   (ps2_clk),
        .ps2_data  (ps2_data),
        .key_code  (key_code),
        .key_ext   (key_ext),
        .key_rel   (key_rel),
        .key_valid (key_valid),
        .key_ready (key_ready),
        .frame_err (frame_err),
        .overflow  (overflow)
    );

    always #10 clk = ~clk;

    typedef struct packed {
        logic [7:0] code;
        logic       ext;
        logic       rel;
    } exp_t;

    exp_t exp_q[$];
    int   tests = 0;
    int   fails = 0;
    int   cyc = 0;
    int   stop_cyc = 0;
    int   last_rise_cyc = -1;
    int   err_seen = 0, err_exp = 0;
    int   ovf_seen = 0, ovf_exp = 0;
    int   lat = 12;
    logic m_ext = 1'b0, m_rel = 1'b0;
    logic kv_prev = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    initial begin
        forever begin
            @(posedge clk);
            cyc++;
        end
    end

    // Monitor: counts pulses and pops the scoreboard on every handshake.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (frame_err) err_seen++;
                if (overflow)  ovf_seen++;
                if (key_valid && !kv_prev) last_rise_cyc = cyc;
                if (key_valid && key_ready) begin
                    if (exp_q.size() == 0) begin
                        tests++;
                        fails++;
                        $display("FAIL spurious_key: got code 0x%0h ext %0b rel %0b, expected none",
                                 key_code, key_ext, key_rel);
                    end else begin
                        e = exp_q.pop_front();
                        check("key_code", {24'd0, key_code}, {24'd0, e.code});
                        check("key_ext", {31'd0, key_ext}, {31'd0, e.ext});
                        check("key_rel", {31'd0, key_rel}, {31'd0, e.rel});
                    end
                end
            end
            kv_prev = key_valid;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // One PS/2 bit: data set while the clock is high, then a low half period.
    // pulse_at > 0 raises key_ready for the single cycle ending pulse_at
    // edges after the clock is pulled low.
    task automatic send_bit(input logic b, input int pulse_at);
        ps2_data = b;
        tick(HALF);
        ps2_clk  = 1'b0;
        stop_cyc = cyc;
        for (int i = 0; i < HALF; i++) begin
            tick(1);
            if (pulse_at > 0) begin
                if (cyc == stop_cyc + pulse_at - 1)  key_ready = 1'b1;
                else if (cyc == stop_cyc + pulse_at) key_ready = 1'b0;
            end
        end
        ps2_clk = 1'b1;
    endtask

    // Reference model + stimulus for a complete frame.
    task automatic frame(input logic [7:0] b, input bit bad_par, input bit bad_stop, input int pulse_at);
        logic p;
        if (bad_par || bad_stop) begin
            err_exp++;
        end else if (b == 8'hE0) begin
            m_ext = 1'b1;
        end else if (b == 8'hF0) begin
            m_rel = 1'b1;
        end else begin
            if (exp_q.size() >= 4 && !key_ready && pulse_at == 0) ovf_exp++;
            else exp_q.push_back({b, m_ext, m_rel});
            m_ext = 1'b0;
            m_rel = 1'b0;
        end
        p = ~(^b) ^ bad_par;
        send_bit(1'b0, 0);
        for (int i = 0; i < 8; i++) send_bit(b[i], 0);
        send_bit(p, 0);
        send_bit(~bad_stop, pulse_at);
        ps2_data = 1'b1;
        tick(HALF);
    endtask

    task automatic drain(input string name);
        key_ready = 1'b1;
        for (int i = 0; i < 200; i++) begin
            if (exp_q.size() == 0 && !key_valid) break;
            tick(1);
        end
        check(name, exp_q.size(), 0);
        check({name, "_valid_low"}, {31'd0, key_valid}, 0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_key_valid"}, {31'd0, key_valid}, 0);
        check({tag, "_key_code"}, {24'd0, key_code}, 0);
        check({tag, "_key_ext"}, {31'd0, key_ext}, 0);
        check({tag, "_key_rel"}, {31'd0, key_rel}, 0);
        check({tag, "_frame_err"}, {31'd0, frame_err}, 0);
        check({tag, "_overflow"}, {31'd0, overflow}, 0);
    endtask

    initial begin
        logic [7:0] b;
        bit         bp, bs;

        // Reset state
        tick(5);
        check_reset_outputs("reset");
        rst_n = 1'b1;
        tick(5);

        // Basic frame and first-key latency
        key_ready = 1'b1;
        last_rise_cyc = -1;
        frame(8'h1C, 0, 0, 0);
        lat = last_rise_cyc - stop_cyc;
        check("valid_latency_in_window", {31'd0, (lat >= 10 && lat <= 14)}, 1);
        if (lat < 10 || lat > 14) lat = 12;
        drain("drain_1c");

        // Extended release sequence
        frame(8'hE0, 0, 0, 0);
        frame(8'hF0, 0, 0, 0);
        frame(8'h75, 0, 0, 0);
        drain("drain_e0f075");

        // Parity error
        frame(8'h1C, 1, 0, 0);
        check("parity_err_count", err_seen, err_exp);
        check("parity_err_no_key", {31'd0, key_valid}, 0);

        // Timeout with an E0 prefix pending: the prefix must survive
        frame(8'hE0, 0, 0, 0);
        send_bit(1'b0, 0);
        send_bit(1'b1, 0);
        send_bit(1'b0, 0);
        send_bit(1'b1, 0);
        tick(49900);
        check("timeout_not_early", err_seen, err_exp);
        tick(300);
        err_exp++;
        check("timeout_err_count", err_seen, err_exp);
        frame(8'h29, 0, 0, 0);
        drain("drain_after_timeout");

        // Short clock glitch in idle with data low
        ps2_data = 1'b0;
        tick(HALF);
        ps2_clk = 1'b0;
        tick(3);
        ps2_clk = 1'b1;
        tick(HALF);
        ps2_data = 1'b1;
        tick(HALF);
        frame(8'h33, 0, 0, 0);
        drain("drain_after_glitch");
        check("glitch_err_count", err_seen, err_exp);

        // Overflow with a stalled consumer
        key_ready = 1'b0;
        for (int i = 1; i <= 5; i++) frame(8'(i), 0, 0, 0);
        check("overflow_count", ovf_seen, ovf_exp);
        check("head_stable_valid", {31'd0, key_valid}, 1);
        check("head_stable_code", {24'd0, key_code}, 32'h01);
        // Push into a full FIFO on the very cycle the head is popped
        frame(8'h06, 0, 0, lat);
        check("full_push_pop_no_overflow", ovf_seen, ovf_exp);
        check("head_after_push_pop", {24'd0, key_code}, 32'h02);
        // Still holding four entries: another stalled push must be dropped
        frame(8'h07, 0, 0, 0);
        check("overflow_after_push_pop", ovf_seen, ovf_exp);
        drain("drain_overflow");

        // Reset in the middle of a frame, with a release prefix pending
        frame(8'hF0, 0, 0, 0);
        send_bit(1'b0, 0);
        send_bit(1'b1, 0);
        send_bit(1'b1, 0);
        ps2_clk = 1'b0;
        tick(HALF);
        rst_n = 1'b0;
        m_ext = 1'b0;
        m_rel = 1'b0;
        exp_q.delete();
        tick(2);
        check_reset_outputs("midframe_reset");
        ps2_clk  = 1'b1;
        ps2_data = 1'b1;
        tick(3);
        rst_n = 1'b1;
        tick(5);
        frame(8'h5A, 0, 0, 0);
        drain("drain_after_reset");

        // Randomised traffic against the model
        for (int n = 0; n < 24; n++) begin
            key_ready = 1'($urandom_range(0, 1));
            case ($urandom_range(0, 9))
                0, 1:    b = 8'hE0;
                2, 3:    b = 8'hF0;
                4:       b = 8'hE1;
                default: b = 8'($urandom_range(0, 255));
            endcase
            bp = ($urandom_range(0, 9) == 0);
            bs = !bp && ($urandom_range(0, 9) == 0);
            frame(b, bp, bs, 0);
        end
        drain("drain_random");
        check("final_err_count", err_seen, err_exp);
        check("final_ovf_count", ovf_seen, ovf_exp);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/ps2_key_rx.md
PS2_KEY_RX -- requirements
Module: ps2_key_rx

Interface
REQ-001 Parameter FILTER_LEN, default 8: consecutive equal synchronized samples required before the filtered PS/2 clock changes level.
REQ-002 Parameter TIMEOUT_CYC, default 50000: clk cycles without a filtered falling edge before a partial frame is abandoned (1 ms at 50 MHz).
REQ-003 clk  input  1  system clock, 50 MHz; all state on its rising edge.
REQ-004 rst_n  input  1  asynchronous active-low reset.
REQ-005 ps2_clk  input  1  PS/2 keyboard clock from mist_io, asynchronous to clk.
REQ-006 ps2_data  input  1  PS/2 keyboard data from mist_io, asynchronous to clk.
REQ-007 key_code  output  8  scancode at FIFO head.
REQ-008 key_ext  output  1  head code was preceded by E0.
REQ-009 key_rel  output  1  head code was preceded by F0 (key release).
REQ-010 key_valid  output  1  FIFO non-empty; key_code/key_ext/key_rel valid.
REQ-011 key_ready  input  1  consumer (keyboard matrix in cobra_top) accepts head when key_valid and key_ready are both high.
REQ-012 frame_err  output  1  one-cycle pulse: parity, stop-bit or timeout error.
REQ-013 overflow  output  1  one-cycle pulse: decoded key dropped because FIFO full.

Function
REQ-014 ps2_clk and ps2_data SHALL pass through 2-flop synchronizers reset to 1.
REQ-015 Filtered clock SHALL change only after FILTER_LEN consecutive equal synchronized samples; reset value 1; a filtered 1->0 transition is a "fall" for exactly one cycle.
REQ-016 Data SHALL be sampled (synchronized value) in the fall cycle.
REQ-017 FSM states IDLE, DATA, PARITY, STOP; reset state IDLE.
REQ-018 IDLE: fall with data=0 -> DATA, bit count 0; fall with data=1 -> stay IDLE, no error.
REQ-019 DATA: each fall shifts data in LSB first; after 8th bit -> PARITY.
REQ-020 PARITY: fall captures parity bit -> STOP; parity OK when XOR of 8 data bits and parity bit = 1 (odd).
REQ-021 STOP: fall -> IDLE; frame accepted iff data=1 and parity OK, else frame_err pulses next cycle and byte discarded.
REQ-022 Timeout counter SHALL clear on every fall and in IDLE; reaching TIMEOUT_CYC outside IDLE -> IDLE, frame_err pulse, prefix flags unchanged.
REQ-023 Accepted byte E0 sets ext_pending, F0 sets rel_pending; neither is pushed to the FIFO.
REQ-024 Any other accepted byte (incl. E1, AA, FA) is pushed as {code, ext_pending, rel_pending}; both pending flags clear in the same cycle, even if the push is dropped.
REQ-025 FIFO: 4 entries of 10 bits, 2-bit pointers wrapping 3->0, 3-bit occupancy count.
REQ-026 Push occurs the cycle after the STOP fall; key_valid registered, rising the cycle after the push when FIFO was empty (2 cycles after the STOP fall).
REQ-027 Push when full with no pop in the same cycle: entry dropped, overflow pulses that cycle, FIFO contents unchanged.
REQ-028 Simultaneous push and pop when full: both SHALL succeed, count stays 4, no overflow.
REQ-029 Simultaneous push and pop when non-full: count unchanged, order preserved.
REQ-030 key_ready while key_valid=0 SHALL be ignored.
REQ-031 key_code/key_ext/key_rel SHALL be held stable while key_valid=1 and key_ready=0.

Reset
REQ-032 rst_n low SHALL immediately force: FSM IDLE, FIFO empty, pointers 0, pending flags 0, counters 0, filters and synchronizers 1, key_code 0x00, key_ext/key_rel/key_valid/frame_err/overflow 0.
REQ-033 Reset mid-frame SHALL discard the partial frame; first post-reset start bit begins a new frame.

Verification
REQ-034 Frame 0x1C (odd parity bit 0, stop 1) -> key_code=0x1C, key_ext=0, key_rel=0, key_valid high 2 cycles after STOP fall.
REQ-035 Frames E0, F0, 0x75 -> single entry key_code=0x75, key_ext=1, key_rel=1; no entries for E0/F0.
REQ-036 Frame 0x1C with parity bit 1 -> frame_err one pulse, key_valid stays 0.
REQ-037 Start + 3 data bits then ps2_clk held high for 50000 cycles -> frame_err pulse, FSM IDLE; next valid 0x29 decodes correctly.
REQ-038 key_ready=0, send 5 codes 0x01..0x05 -> overflow pulse on 5th; pops return 0x01..0x04; then full-FIFO push with key_ready=1 -> no overflow, count 4.
REQ-039 3-cycle low glitch on ps2_clk in IDLE -> no fall, no state change.
